// File: rtl/median_pkg.sv
// Shared types and constants for the median filter front end.
package median_pkg;

  localparam int DATA_W = 24;
  localparam int Y_W    = 16;

  typedef logic [DATA_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } lwc_state_t;

endpackage

// File: rtl/bram.sv
// Single-port read-first block RAM with a registered read port.
module bram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Read returns the old contents when the same address is written.
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= din;
    dout <= r_mem[addr];
  end

endmodule

// File: rtl/raster_pos_cnt.sv
// Raster x/y position tracking. o_x/o_y give the position of the pixel
// offered this cycle (forced to 0,0 when it carries a start of frame).
module raster_pos_cnt #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 12,
  parameter int Y_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_accept,
  input  logic              i_sof,
  output logic [ADDR_W-1:0] o_x,
  output logic [Y_W-1:0]    o_y,
  output logic              o_eol,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_x;
  logic [Y_W-1:0]    r_y;

  assign o_x    = i_sof ? '0 : r_x;
  assign o_y    = i_sof ? '0 : r_y;
  assign o_eol  = (o_x == ADDR_W'(IMG_W - 1));
  assign o_last = o_eol && (o_y == Y_W'(IMG_H - 1));

  // Advance past the accepted pixel; wrap to the origin after the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_accept) begin
      if (o_last) begin
        r_x <= '0;
        r_y <= '0;
      end else if (o_eol) begin
        r_x <= '0;
        r_y <= o_y + 1'b1;
      end else begin
        r_x <= o_x + 1'b1;
        r_y <= o_y;
      end
    end
  end

endmodule

// File: rtl/line_window_ctrl.sv
// Line-buffer sequencer for the 3x3 median filter: turns a raster stream
// into vertical 3-pixel columns using two chained line-buffer BRAMs.
// Optional build macro: MEDIAN_ZERO_PAD_EN (emit columns for rows 0-1 with
// the missing rows forced to zero).
//
// state | meaning
// IDLE  | waiting for a start of frame, other pixels dropped
// FILL  | rows 0-1, line buffers being primed
// RUN   | rows 2..IMG_H-1, full columns available
module line_window_ctrl #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 12,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_sof,
  input  logic [DATA_W-1:0]          in_pixel,
  output logic                       col_valid,
  output logic [DATA_W-1:0]          col_top,
  output logic [DATA_W-1:0]          col_mid,
  output logic [DATA_W-1:0]          col_bot,
  output logic [ADDR_W-1:0]          col_x,
  output logic [median_pkg::Y_W-1:0] col_y,
  output logic                       frame_done
);

  import median_pkg::*;

  lwc_state_t r_state;

  logic              w_sof, w_accept, w_eol, w_last;
  logic [ADDR_W-1:0] w_x;
  logic [Y_W-1:0]    w_y;

  assign w_sof    = in_valid && in_sof;
  assign w_accept = in_valid && (in_sof || (r_state != IDLE));

  raster_pos_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .Y_W   (Y_W)
  ) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_accept(w_accept),
    .i_sof   (w_sof),
    .o_x     (w_x),
    .o_y     (w_y),
    .o_eol   (w_eol),
    .o_last  (w_last)
  );

  // Frame sequencing; a start of frame always restarts at (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (w_accept) begin
      if (w_last) r_state <= IDLE;
      else if (w_sof) r_state <= FILL;
      else if ((r_state == FILL) && w_eol && (w_y == Y_W'(1))) r_state <= RUN;
    end
  end

  // Line buffer 0 holds row y-1, line buffer 1 holds row y-2.
  logic [ADDR_W-1:0] r_b0_addr, r_b1_addr, w_b0_addr, w_b1_addr;
  logic [DATA_W-1:0] w_b0_dout, w_b1_dout;

  logic              r_s1_valid, r_s1_last;
  logic [ADDR_W-1:0] r_s1_x;
  logic [Y_W-1:0]    r_s1_y;
  logic [DATA_W-1:0] r_s1_pix;

  logic              r_s2_valid, r_s2_last;
  logic [ADDR_W-1:0] r_s2_x;
  logic [Y_W-1:0]    r_s2_y;
  logic [DATA_W-1:0] r_s2_pix, r_s2_mid;

  // Addresses hold their last value on idle cycles.
  assign w_b0_addr = w_accept ? w_x : r_b0_addr;
  assign w_b1_addr = r_s1_valid ? r_s1_x : r_b1_addr;

  bram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bram0 (
    .clk (clk),
    .we  (w_accept),
    .addr(w_b0_addr),
    .din (in_pixel),
    .dout(w_b0_dout)
  );

  bram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bram1 (
    .clk (clk),
    .we  (r_s1_valid),
    .addr(w_b1_addr),
    .din (w_b0_dout),
    .dout(w_b1_dout)
  );

  // Two pipeline stages track each accepted pixel alongside the BRAM reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_b0_addr  <= '0;
      r_b1_addr  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_pix   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_x     <= '0;
      r_s2_y     <= '0;
      r_s2_pix   <= '0;
      r_s2_mid   <= '0;
    end else begin
      r_b0_addr  <= w_b0_addr;
      r_b1_addr  <= w_b1_addr;
      r_s1_valid <= w_accept;
      r_s1_last  <= w_accept && w_last;
      if (w_accept) begin
        r_s1_x   <= w_x;
        r_s1_y   <= w_y;
        r_s1_pix <= in_pixel;
      end
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      if (r_s1_valid) begin
        r_s2_x   <= r_s1_x;
        r_s2_y   <= r_s1_y;
        r_s2_pix <= r_s1_pix;
        r_s2_mid <= w_b0_dout;
      end
    end
  end

  logic              w_emit;
  logic [DATA_W-1:0] w_top, w_mid;

`ifdef MEDIAN_ZERO_PAD_EN
  // Rows above the frame are zero so stale line-buffer data never escapes.
  assign w_emit = r_s2_valid;
  assign w_top  = (r_s2_y < Y_W'(2)) ? '0 : w_b1_dout;
  assign w_mid  = (r_s2_y == '0) ? '0 : r_s2_mid;
`else
  assign w_emit = r_s2_valid && (r_s2_y >= Y_W'(2));
  assign w_top  = w_b1_dout;
  assign w_mid  = r_s2_mid;
`endif

  // Output register; data holds while no column is emitted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_valid  <= 1'b0;
      col_top    <= '0;
      col_mid    <= '0;
      col_bot    <= '0;
      col_x      <= '0;
      col_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      col_valid  <= w_emit;
      frame_done <= r_s2_valid && r_s2_last;
      if (w_emit) begin
        col_top <= w_top;
        col_mid <= w_mid;
        col_bot <= r_s2_pix;
        col_x   <= r_s2_x;
        col_y   <= r_s2_y;
      end
    end
  end

endmodule

// File: tb/tb_line_window_ctrl.sv
// Bench for line_window_ctrl on a 4x4 image: scoreboard model of the raster
// rules plus a table of expected columns for the canonical frame.
module tb_line_window_ctrl;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 24;
  localparam int AW = 12;
`ifdef MEDIAN_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_sof;
  logic [DW-1:0] in_pixel;
  logic          col_valid, frame_done;
  logic [DW-1:0] col_top, col_mid, col_bot;
  logic [AW-1:0] col_x;
  logic [15:0]   col_y;

  always #5 clk = ~clk;

  line_window_ctrl #(.DATA_W(DW), .ADDR_W(AW), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .col_valid (col_valid),
    .col_top   (col_top),
    .col_mid   (col_mid),
    .col_bot   (col_bot),
    .col_x     (col_x),
    .col_y     (col_y),
    .frame_done(frame_done)
  );

  typedef struct {
    int            due;
    int            x;
    int            y;
    logic [DW-1:0] t;
    logic [DW-1:0] m;
    logic [DW-1:0] b;
    bit            last;
  } exp_t;

  typedef struct {
    int            x;
    int            y;
    logic [DW-1:0] t;
    logic [DW-1:0] m;
    logic [DW-1:0] b;
    bit            done;
  } col_t;

  exp_t q[$];
  col_t cap[$];
  col_t tbl[$];

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int gap_idx = 0;

  bit            in_frame;
  int            n_pix;
  logic [DW-1:0] mem [H][W];
  int            lx, ly;
  logic [DW-1:0] lt, lm, lb;

  task automatic chk(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    q.delete();
    in_frame = 1'b0;
    n_pix = 0;
    lx = 0; ly = 0; lt = '0; lm = '0; lb = '0;
  endtask

  // A pixel presented in cycle t (sampled at edge k) shows up in cycle t+3,
  // i.e. right after edge k+2.
  task automatic model_accept(bit v, bit s, logic [DW-1:0] p);
    int x, y;
    exp_t e;
    if (!v) return;
    if (s) begin
      n_pix = 0;
      in_frame = 1'b1;
    end else if (!in_frame) begin
      return;
    end
    x = n_pix % W;
    y = n_pix / W;
    mem[y][x] = p;
    if (PAD || y >= 2) begin
      e.due  = edge_n + 2;
      e.x    = x;
      e.y    = y;
      e.t    = (y >= 2) ? mem[y-2][x] : '0;
      e.m    = (y >= 1) ? mem[y-1][x] : '0;
      e.b    = p;
      e.last = (n_pix == W*H-1);
      q.push_back(e);
    end
    if (n_pix == W*H-1) in_frame = 1'b0;
    n_pix++;
  endtask

  task automatic check_outputs();
    bit   ev;
    exp_t e;
    col_t c;
    ev = (q.size() > 0) && (q[0].due == edge_n);
    chk("col_valid", col_valid, ev);
    if (col_valid) begin
      c.x = int'(col_x); c.y = int'(col_y);
      c.t = col_top; c.m = col_mid; c.b = col_bot; c.done = frame_done;
      cap.push_back(c);
    end
    if (ev) begin
      e = q.pop_front();
      lx = e.x; ly = e.y; lt = e.t; lm = e.m; lb = e.b;
      chk("frame_done", frame_done, e.last);
    end else begin
      chk("frame_done_idle", frame_done, 0);
    end
    chk("col_x", col_x, lx);
    chk("col_y", col_y, ly);
    chk("col_top", col_top, lt);
    chk("col_mid", col_mid, lm);
    chk("col_bot", col_bot, lb);
  endtask

  task automatic step(bit v, bit s, logic [DW-1:0] p);
    in_valid = v;
    in_sof   = s;
    in_pixel = p;
    @(posedge clk);
    edge_n++;
    #1;
    if (!rst_n) model_reset();
    check_outputs();
    if (rst_n) model_accept(v, s, p);
  endtask

  task automatic idle(int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0);
  endtask

  // Sends pixels first..last-1 of a frame; value 16*y+x or all ones.
  task automatic send_pixels(int first, int last, bit gaps, bit ones);
    bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = first; k < last; k++) begin
      if (gaps) begin
        while (!pat[gap_idx % 5]) begin
          gap_idx++;
          step(1'b0, 1'b0, '0);
        end
        gap_idx++;
      end
      step(1'b1, (k == 0), ones ? {DW{1'b1}} : DW'(16 * (k / W) + (k % W)));
    end
  endtask

  task automatic check_table(string nm, int off);
    chk({nm, "_count"}, cap.size(), off + tbl.size());
    for (int i = 0; i < tbl.size(); i++) begin
      if (off + i < cap.size()) begin
        chk({nm, "_x"},    cap[off+i].x,    tbl[i].x);
        chk({nm, "_y"},    cap[off+i].y,    tbl[i].y);
        chk({nm, "_top"},  cap[off+i].t,    tbl[i].t);
        chk({nm, "_mid"},  cap[off+i].m,    tbl[i].m);
        chk({nm, "_bot"},  cap[off+i].b,    tbl[i].b);
        chk({nm, "_done"}, cap[off+i].done, tbl[i].done);
      end
    end
  endtask

  initial begin
    col_t c;
    bit   v, s;

    // Expected columns of the canonical 16*y+x frame.
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (PAD || y >= 2) begin
          c.x = x; c.y = y;
          c.t = (y >= 2) ? DW'(16 * (y - 2) + x) : '0;
          c.m = (y >= 1) ? DW'(16 * (y - 1) + x) : '0;
          c.b = DW'(16 * y + x);
          c.done = (x == W-1) && (y == H-1);
          tbl.push_back(c);
        end
      end
    end

    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Continuous frame
    cap.delete();
    send_pixels(0, W*H, 1'b0, 1'b0);
    idle(5);
    check_table("cont", 0);

    // Gapped frame, valid pattern 1,0,0,1,0
    cap.delete();
    gap_idx = 0;
    send_pixels(0, W*H, 1'b1, 1'b0);
    idle(5);
    check_table("gap", 0);

    // Pixels without sof while idle are dropped
    cap.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 24'hABCDEF);
    send_pixels(0, W*H, 1'b0, 1'b0);
    idle(5);
    check_table("drop", 0);

    // Restart on pixel (1,2): the in-flight columns drain, then the new frame
    cap.delete();
    send_pixels(0, 2*W+1, 1'b0, 1'b0);
    send_pixels(0, W*H, 1'b0, 1'b0);
    idle(5);
    check_table("abort", PAD ? 2*W+1 : 1);

    // Reset mid-frame, then stray pixels, then a clean frame
    send_pixels(0, 6, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 24'h000055);
    step(1'b1, 1'b0, 24'h000066);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'h000077);
    idle(3);
    cap.delete();
    send_pixels(0, W*H, 1'b0, 1'b0);
    idle(5);
    check_table("after_rst", 0);

    // Frame of all ones then a normal frame: stale data must not leak
    send_pixels(0, W*H, 1'b0, 1'b1);
    idle(4);
    cap.delete();
    send_pixels(0, W*H, 1'b0, 1'b0);
    idle(5);
    check_table("stale", 0);

    // Random traffic with sporadic restarts
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 2) != 0);
      s = v && (in_frame ? ($urandom_range(0, 40) == 0) : ($urandom_range(0, 3) == 0));
      step(v, s, DW'($urandom));
    end
    idle(6);
    chk("drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
